// File: rtl/asm_rr_sched.sv
// asm_rr_sched: round-robin scheduler sharing one f(n) ASM engine among NREQ requesters.
//  Arbitrates pending requests, starts the engine with the winner's operand, waits for the
//  engine's done_tick and returns the result to the winner with a one-cycle ack. A watchdog
//  resets a hung engine and completes the request with rsp_err set.
// Ports:
//  clk, reset_n          clock, asynchronous active-low reset
//  req, req_din          per-requester request level and packed operands (DW bits each)
//  ack, rsp_dout, rsp_err one-hot completion pulse, held result, timeout flag with ack
//  busy, err_timeout     scheduler not idle, one-cycle watchdog pulse
//  eng_start, eng_din    engine start pulse and latched operand
//  eng_reset             active-high engine reset (held while reset_n is low)
//  eng_dout, eng_done_tick engine result and completion pulse
module asm_rr_sched #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DW      = 4,
   parameter int unsigned RW      = 7,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_din,
   output logic [NREQ-1:0]      ack,
   output logic [RW-1:0]        rsp_dout,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 err_timeout,
   output logic                 eng_start,
   output logic [DW-1:0]        eng_din,
   output logic                 eng_reset,
   input  logic [RW-1:0]        eng_dout,
   input  logic                 eng_done_tick
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_RECOVER
   } state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     gnt_q, gnt_d;
   logic [IW-1:0]     last_gnt_q, last_gnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [DW-1:0]     eng_din_q, eng_din_d;
   logic [RW-1:0]     rsp_dout_q, rsp_dout_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              rsp_err_q, rsp_err_d;
   logic              busy_q, busy_d;
   logic              err_timeout_q, err_timeout_d;
   logic              eng_start_q, eng_start_d;
   logic              eng_reset_q, eng_reset_d;

   logic [DW-1:0]     din_arr [NREQ];
   logic [IW-1:0]     cand_c;
   logic [IW-1:0]     pick_c;

   // Unpack operands so the winner can be selected by index.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
      assign din_arr[gi] = req_din[gi*DW +: DW];
   end

   // Round-robin pick: scan downward in offset so the nearest requester after last_gnt wins.
   always_comb begin
      cand_c = '0;
      pick_c = last_gnt_q;
      for (int k = int'(NREQ); k >= 1; k--) begin
         cand_c = IW'((int'(last_gnt_q) + k) % int'(NREQ));
         if (req[cand_c]) begin
            pick_c = cand_c;
         end
      end
   end

   // Next-state and registered-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      last_gnt_d    = last_gnt_q;
      timer_d       = timer_q;
      eng_din_d     = eng_din_q;
      rsp_dout_d    = rsp_dout_q;
      ack_d         = '0;
      rsp_err_d     = 1'b0;
      err_timeout_d = 1'b0;
      eng_start_d   = 1'b0;
      eng_reset_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               gnt_d       = pick_c;
               eng_din_d   = din_arr[pick_c];
               eng_start_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            // done_tick wins over the watchdog in the same cycle.
            if (eng_done_tick) begin
               rsp_dout_d = eng_dout;
               ack_d      = NREQ'(1) << gnt_q;
               state_d    = S_RESP;
            end else if (timer_q == TW'(TIMEOUT)) begin
               rsp_dout_d    = '0;
               ack_d         = NREQ'(1) << gnt_q;
               rsp_err_d     = 1'b1;
               err_timeout_d = 1'b1;
               eng_reset_d   = 1'b1;
               state_d       = S_RECOVER;
            end
         end
         S_RESP: begin
            last_gnt_d = gnt_q;
            state_d    = S_IDLE;
         end
         S_RECOVER: begin
            last_gnt_d = gnt_q;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; eng_reset is held high throughout reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         gnt_q         <= '0;
         last_gnt_q    <= IW'(NREQ - 1);
         timer_q       <= '0;
         eng_din_q     <= '0;
         rsp_dout_q    <= '0;
         ack_q         <= '0;
         rsp_err_q     <= 1'b0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         eng_start_q   <= 1'b0;
         eng_reset_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         last_gnt_q    <= last_gnt_d;
         timer_q       <= timer_d;
         eng_din_q     <= eng_din_d;
         rsp_dout_q    <= rsp_dout_d;
         ack_q         <= ack_d;
         rsp_err_q     <= rsp_err_d;
         busy_q        <= busy_d;
         err_timeout_q <= err_timeout_d;
         eng_start_q   <= eng_start_d;
         eng_reset_q   <= eng_reset_d;
      end
   end

   assign ack         = ack_q;
   assign rsp_dout    = rsp_dout_q;
   assign rsp_err     = rsp_err_q;
   assign busy        = busy_q;
   assign err_timeout = err_timeout_q;
   assign eng_start   = eng_start_q;
   assign eng_din     = eng_din_q;
   assign eng_reset   = eng_reset_q;

endmodule

// File: tb/tb_asm_rr_sched.sv
// tb_asm_rr_sched: self-checking bench for asm_rr_sched with a transaction-level reference
//  model (grant cycle, latency-derived ack cycle, rotating priority) and an engine model.
module tb_asm_rr_sched;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned DW      = 4;
   localparam int unsigned RW      = 7;
   localparam int unsigned TIMEOUT = 31;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req;
   logic [NREQ*DW-1:0]  req_din;
   logic [NREQ-1:0]     ack;
   logic [RW-1:0]       rsp_dout;
   logic                rsp_err;
   logic                busy;
   logic                err_timeout;
   logic                eng_start;
   logic [DW-1:0]       eng_din;
   logic                eng_reset;
   logic [RW-1:0]       eng_dout;
   logic                eng_done_tick;

   asm_rr_sched #(
      .NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_din(req_din),
      .ack(ack), .rsp_dout(rsp_dout), .rsp_err(rsp_err), .busy(busy),
      .err_timeout(err_timeout), .eng_start(eng_start), .eng_din(eng_din),
      .eng_reset(eng_reset), .eng_dout(eng_dout), .eng_done_tick(eng_done_tick)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc;

   // Requester agents
   logic [NREQ-1:0] want;
   logic [DW-1:0]   opnd [NREQ];
   bit              pend [NREQ];
   int              mode;        // 0: drop on ack, 1: hold, 2: random
   bit              spur_en;
   bit              hang;

   // Transaction-level reference model
   bit              m_busy;
   int              m_gnt, m_last, m_gcyc, m_ackc, m_free;
   logic [DW-1:0]   m_din;
   bit              m_hang;
   logic [RW-1:0]   m_hold;

   int              e_cnt;
   logic [DW-1:0]   e_din;

   int log_who[$];
   int log_dout[$];
   int log_err[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [RW-1:0] eng_res(input logic [DW-1:0] d);
      int v;
      if (d == '0) return RW'(1);
      v = (1 + 5 * (int'(d) + 1)) % (1 << RW);
      return RW'(v);
   endfunction

   task automatic drive();
      req = want;
      for (int i = 0; i < int'(NREQ); i++) req_din[i*DW +: DW] = opnd[i];
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_gnt = 0; m_last = int'(NREQ) - 1; m_gcyc = -10; m_ackc = -10;
      m_free = 0; m_din = '0; m_hang = 1'b0; m_hold = '0;
      e_cnt = 0; e_din = '0; cyc = 0;
      want = '0;
      for (int i = 0; i < int'(NREQ); i++) begin opnd[i] = '0; pend[i] = 1'b0; end
      eng_done_tick = 1'b0; eng_dout = '0;
      drive();
   endtask

   task automatic clear_log();
      log_who.delete(); log_dout.delete(); log_err.delete();
   endtask

   task automatic reset_checks();
      chk("rst_ack", 32'(ack), 32'(0));
      chk("rst_rsp_dout", 32'(rsp_dout), 32'(0));
      chk("rst_rsp_err", 32'(rsp_err), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_err_timeout", 32'(err_timeout), 32'(0));
      chk("rst_eng_start", 32'(eng_start), 32'(0));
      chk("rst_eng_din", 32'(eng_din), 32'(0));
      chk("rst_eng_reset", 32'(eng_reset), 32'(1));
   endtask

   // One cycle, called at the negedge: check outputs, run engine, agents, then arbitration.
   task automatic step();
      logic [NREQ-1:0] exp_ack;
      bit              at_ack, dn, gi;
      int              who, ack_id, g;
      logic [RW-1:0]   dv;

      at_ack  = m_busy && (cyc == m_ackc);
      exp_ack = '0;
      if (at_ack) exp_ack[m_gnt] = 1'b1;
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("busy", 32'(busy), 32'(m_busy && cyc > m_gcyc));
      chk("eng_start", 32'(eng_start), 32'(m_busy && cyc == m_gcyc + 1));
      if (m_busy && cyc > m_gcyc && cyc < m_ackc) chk("eng_din", 32'(eng_din), 32'(m_din));
      chk("rsp_err", 32'(rsp_err), 32'(at_ack && m_hang));
      chk("err_timeout", 32'(err_timeout), 32'(at_ack && m_hang));
      chk("eng_reset", 32'(eng_reset), 32'(at_ack && m_hang));
      if (at_ack) m_hold = m_hang ? '0 : eng_res(m_din);
      chk("rsp_dout", 32'(rsp_dout), 32'(m_hold));

      ack_id = -1;
      if (at_ack) begin
         who = -1;
         for (int i = 0; i < int'(NREQ); i++) if (ack[i]) who = i;
         log_who.push_back(who);
         log_dout.push_back(int'(rsp_dout));
         log_err.push_back(int'(rsp_err));
         ack_id = m_gnt;
         m_last = m_gnt;
         m_busy = 1'b0;
         m_free = cyc + 1;
      end

      // Engine: done after 1 cycle for din==0, din+2 otherwise; silent when hung.
      dn = 1'b0;
      dv = RW'($urandom);
      if (eng_reset) e_cnt = 0;
      if (eng_start) begin
         e_din = eng_din;
         e_cnt = hang ? 0 : ((eng_din == '0) ? 1 : int'(eng_din) + 2);
      end else if (e_cnt > 0) begin
         e_cnt--;
         if (e_cnt == 0) begin dn = 1'b1; dv = eng_res(e_din); end
      end else if (spur_en && !m_busy && $urandom_range(0, 5) == 0) begin
         dn = 1'b1;
      end
      eng_done_tick = dn;
      eng_dout      = dv;

      if (mode == 2) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            gi = m_busy && (m_gnt == i);
            if (ack_id == i) begin
               pend[i] = 1'b0; want[i] = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  pend[i] = 1'b1; want[i] = 1'b1; opnd[i] = DW'($urandom);
               end
            end else if (pend[i] && gi) begin
               if ($urandom_range(0, 3) == 0) want[i] = 1'b0;
               opnd[i] = DW'($urandom);
            end else if (pend[i]) begin
               if ($urandom_range(0, 11) == 0) begin pend[i] = 1'b0; want[i] = 1'b0; end
            end else if ($urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1; want[i] = 1'b1; opnd[i] = DW'($urandom);
            end
         end
      end else if (mode == 0 && ack_id >= 0) begin
         want[ack_id] = 1'b0;
      end
      drive();

      // Grant: first requester after the last winner, with wrap.
      if (!m_busy && cyc >= m_free && want != '0) begin
         g = -1;
         for (int k = 1; k <= int'(NREQ); k++) begin
            if (g < 0 && want[(m_last + k) % int'(NREQ)]) g = (m_last + k) % int'(NREQ);
         end
         m_busy = 1'b1;
         m_gnt  = g;
         m_gcyc = cyc;
         m_din  = opnd[g];
         m_hang = hang;
         m_ackc = cyc + (hang ? int'(TIMEOUT) + 3 : ((opnd[g] == '0) ? 3 : int'(opnd[g]) + 4));
      end
      cyc++;
   endtask

   task automatic run_until_log(input int n, input int budget);
      int b = 0;
      while (log_who.size() < n && b < budget) begin
         @(negedge clk);
         step();
         b++;
      end
      if (log_who.size() < n) chk("ack_count_timeout", 32'(log_who.size()), 32'(n));
   endtask

   task automatic drain(input int budget);
      int b = 0;
      while (m_busy && b < budget) begin
         @(negedge clk);
         step();
         b++;
      end
      if (m_busy) chk("drain_timeout", 32'(m_busy), 32'(0));
   endtask

   initial begin
      reset_n = 1'b1;
      mode = 0; spur_en = 1'b0; hang = 1'b0;
      model_reset();
      #3 reset_n = 1'b0;
      @(negedge clk);
      reset_checks();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // All four requesters from reset: served 0,1,2,3.
      clear_log();
      want = 4'b1111;
      opnd[0] = 4'd1; opnd[1] = 4'd2; opnd[2] = 4'd3; opnd[3] = 4'd4;
      run_until_log(4, 200);
      if (log_who.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("all4_who", 32'(log_who[i]), 32'(i));
            chk("all4_dout", 32'(log_dout[i]), 32'(11 + 5 * i));
         end
      end

      // Single request, din=0.
      clear_log();
      want = 4'b0001; opnd[0] = 4'd0;
      run_until_log(1, 50);
      if (log_who.size() == 1) begin
         chk("din0_who", 32'(log_who[0]), 32'(0));
         chk("din0_dout", 32'(log_dout[0]), 32'(1));
         chk("din0_err", 32'(log_err[0]), 32'(0));
      end

      // Single request, din=3.
      clear_log();
      want = 4'b0010; opnd[1] = 4'd3;
      run_until_log(1, 50);
      if (log_who.size() == 1) begin
         chk("din3_who", 32'(log_who[0]), 32'(1));
         chk("din3_dout", 32'(log_dout[0]), 32'(21));
      end

      // Requesters 0 and 2 held high: grants must alternate (last winner was 1, so 2 first).
      clear_log();
      mode = 1;
      want = 4'b0101; opnd[0] = 4'd0; opnd[2] = 4'd0;
      run_until_log(4, 100);
      want = '0;
      mode = 0;
      drain(100);
      if (log_who.size() >= 4) begin
         chk("alt_first", 32'(log_who[0]), 32'(2));
         for (int i = 1; i < 4; i++)
            chk("alt_who", 32'(log_who[i]), 32'((log_who[i-1] == 0) ? 2 : 0));
      end

      // Hung engine: watchdog recovery.
      clear_log();
      hang = 1'b1;
      want = 4'b1000; opnd[3] = 4'd5;
      run_until_log(1, 100);
      hang = 1'b0;
      if (log_who.size() == 1) begin
         chk("hang_who", 32'(log_who[0]), 32'(3));
         chk("hang_dout", 32'(log_dout[0]), 32'(0));
         chk("hang_err", 32'(log_err[0]), 32'(1));
      end

      // Randomized traffic with spurious done_ticks and occasional hung transactions.
      mode = 2; spur_en = 1'b1;
      for (int i = 0; i < int'(NREQ); i++) pend[i] = 1'b0;
      want = '0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!m_busy && $urandom_range(0, 150) == 0) hang = !hang;
         step();
      end
      mode = 0; want = '0;
      drain(100);
      hang = 1'b0; spur_en = 1'b0;

      // Reset in the middle of WAIT, then requester 1 must win over 3.
      clear_log();
      want = 4'b0001; opnd[0] = 4'd9;
      begin
         int b = 0;
         while (!(m_busy && cyc - 1 == m_gcyc + 4) && b < 50) begin
            @(negedge clk);
            step();
            b++;
         end
         chk("midwait_reached", 32'(m_busy), 32'(1));
      end
      #2 reset_n = 1'b0;
      #1 reset_checks();
      model_reset();
      clear_log();
      repeat (2) @(negedge clk);
      reset_checks();
      reset_n = 1'b1;
      want = 4'b1010; opnd[1] = 4'd2; opnd[3] = 4'd5;
      run_until_log(1, 50);
      if (log_who.size() == 1) begin
         chk("post_rst_who", 32'(log_who[0]), 32'(1));
         chk("post_rst_dout", 32'(log_dout[0]), 32'(16));
      end
      want = '0;
      drain(100);
      repeat (3) begin @(negedge clk); step(); end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
